// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, widths, FSM states
// and the packed command word carried through the FIFO.
package alu_pkg;

  localparam int OPW  = 4;
  localparam int DW   = 4;
  localparam int RW   = 8;
  localparam int CMDW = OPW + 2 * DW + 1;

  localparam logic [OPW-1:0] OP_ZERO  = 4'h0;
  localparam logic [OPW-1:0] OP_PASSA = 4'h1;
  localparam logic [OPW-1:0] OP_PASSB = 4'h2;
  localparam logic [OPW-1:0] OP_ADD   = 4'h3;
  localparam logic [OPW-1:0] OP_SUB   = 4'h4;
  localparam logic [OPW-1:0] OP_MUL   = 4'h5;
  localparam logic [OPW-1:0] OP_DIV   = 4'h6;
  localparam logic [OPW-1:0] OP_MOD   = 4'h7;
  localparam logic [OPW-1:0] OP_AND   = 4'h8;
  localparam logic [OPW-1:0] OP_OR    = 4'h9;
  localparam logic [OPW-1:0] OP_NOT   = 4'hA;
  localparam logic [OPW-1:0] OP_SHL   = 4'hB;
  localparam logic [OPW-1:0] OP_SHR   = 4'hC;
  localparam logic [OPW-1:0] OP_XOR   = 4'hD;
  localparam logic [OPW-1:0] OP_EQ    = 4'hE;
  localparam logic [OPW-1:0] OP_GT    = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPW-1:0] opcode;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic           cin;
  } cmd_t;

  // The ALU output is meaningless for a zero divisor; the issuer flags it.
  function automatic logic is_div_zero(input cmd_t c);
    return (c.opcode == OP_DIV) && (c.b == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head word is presented
// continuously so the issuer can latch it into its issue register on pop.
module alu_cmd_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands, drives them one at a time onto the combinational ALU
// from registers, and returns each captured result over a valid/ready port.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [OPW-1:0] cmd_opcode,
  input  logic [DW-1:0]  cmd_a,
  input  logic [DW-1:0]  cmd_b,
  input  logic           cmd_cin,
  output logic [OPW-1:0] alu_opcode,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic           alu_cin,
  input  logic [RW-1:0]  alu_result,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [RW-1:0]  rsp_data,
  output logic [OPW-1:0] rsp_opcode,
  output logic           rsp_zero,
  output logic           rsp_err,
  output logic           busy,
  output logic [7:0]     rsp_count
);

  state_t          state_reg;
  cmd_t            issue_reg;
  cmd_t            push_cmd;
  cmd_t            head_cmd;
  logic [CMDW-1:0] head_bits;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            div_zero;
  logic [RW-1:0]   result_final;

  logic            rsp_valid_reg;
  logic [RW-1:0]   rsp_data_reg;
  logic [OPW-1:0]  rsp_opcode_reg;
  logic            rsp_zero_reg;
  logic            rsp_err_reg;
  logic [7:0]      rsp_count_reg;

  assign push_cmd = {cmd_opcode, cmd_a, cmd_b, cmd_cin};
  assign head_cmd = cmd_t'(head_bits);

  alu_cmd_fifo #(
    .WIDTH (CMDW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The head moves into the issue register only when the ALU slot frees up.
  assign pop = !fifo_empty &&
               ((state_reg == ST_IDLE) || ((state_reg == ST_RESP) && rsp_ready));

  assign div_zero     = is_div_zero(issue_reg);
  assign result_final = div_zero ? 8'hFF : alu_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      issue_reg      <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_opcode_reg <= '0;
      rsp_zero_reg   <= 1'b0;
      rsp_err_reg    <= 1'b0;
      rsp_count_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            issue_reg <= head_cmd;
            state_reg <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          rsp_data_reg   <= result_final;
          rsp_opcode_reg <= issue_reg.opcode;
          rsp_zero_reg   <= (result_final == '0);
          rsp_err_reg    <= div_zero;
          rsp_valid_reg  <= 1'b1;
          state_reg      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rsp_count_reg <= rsp_count_reg + 8'd1;
            if (pop) begin
              issue_reg <= head_cmd;
              state_reg <= ST_DRIVE;
            end else begin
              issue_reg <= '0;
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = !fifo_full;
  assign busy       = (state_reg != ST_IDLE) || !fifo_empty;

  assign alu_opcode = issue_reg.opcode;
  assign alu_a      = issue_reg.a;
  assign alu_b      = issue_reg.b;
  assign alu_cin    = issue_reg.cin;

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_opcode = rsp_opcode_reg;
  assign rsp_zero   = rsp_zero_reg;
  assign rsp_err    = rsp_err_reg;
  assign rsp_count  = rsp_count_reg;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a transaction-level model and a
// stand-in combinational ALU.
module tb_alu_cmd_issuer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_opcode = '0;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic       cmd_cin = 1'b0;
  logic [3:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_cin;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [3:0] rsp_opcode;
  logic       rsp_zero;
  logic       rsp_err;
  logic       busy;
  logic [7:0] rsp_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [7:0] data;
    logic       zero;
    logic       err;
  } txn_t;

  txn_t       mq[$];
  txn_t       rlog[$];
  logic [7:0] mcnt = '0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_cin    (cmd_cin),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_opcode (rsp_opcode),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .rsp_count  (rsp_count)
  );

  // Stand-in ALU; a zero divisor returns 0 so the issuer's 0xFF override shows.
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic cin);
    logic [7:0] xa, xb;
    xa = {4'h0, a};
    xb = {4'h0, b};
    case (op)
      4'h0: return 8'h00;
      4'h1: return xa;
      4'h2: return xb;
      4'h3: return xa + xb + {7'd0, cin};
      4'h4: return xa - xb - {7'd0, cin};
      4'h5: return xa * xb;
      4'h6: return (b == 0) ? 8'h00 : xa / xb;
      4'h7: return (b == 0) ? 8'h00 : xa % xb;
      4'h8: return xa & xb;
      4'h9: return xa | xb;
      4'hA: return {4'h0, ~a};
      4'hB: return xa << 1;
      4'hC: return xa >> 1;
      4'hD: return xa ^ xb;
      4'hE: return (a == b) ? 8'h01 : 8'h00;
      default: return (a > b) ? 8'h01 : 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_a, alu_b, alu_cin);

  function automatic txn_t expect_of(input logic [3:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic cin);
    txn_t t;
    t.op   = op;
    t.a    = a;
    t.b    = b;
    t.cin  = cin;
    t.err  = (op == 4'h6) && (b == 4'h0);
    t.data = t.err ? 8'hFF : alu_f(op, a, b, cin);
    t.zero = (t.data == 8'h00);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Handshake monitor: updates the model on each edge from pre-edge values.
  initial begin
    txn_t       e, g;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [3:0] prev_op = '0;
    logic       prev_zero = 1'b0, prev_err = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        mcnt = '0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_data", rsp_data, prev_data);
          chk("stall_opcode", rsp_opcode, prev_op);
          chk("stall_zero", rsp_zero, prev_zero);
          chk("stall_err", rsp_err, prev_err);
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_data  = rsp_data;
        prev_op    = rsp_opcode;
        prev_zero  = rsp_zero;
        prev_err   = rsp_err;
        if (rsp_valid && rsp_ready) begin
          if (mq.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
          end else begin
            e = mq.pop_front();
            g = e;
            g.data = rsp_data;
            g.zero = rsp_zero;
            g.err  = rsp_err;
            g.op   = rsp_opcode;
            rlog.push_back(g);
            $display("rsp op=%h a=%h b=%h cin=%b data=%02h zero=%b err=%b count=%0d",
                     e.op, e.a, e.b, e.cin, rsp_data, rsp_zero, rsp_err, mcnt + 8'd1);
          end
          mcnt = mcnt + 8'd1;
        end
        if (cmd_valid && cmd_ready)
          mq.push_back(expect_of(cmd_opcode, cmd_a, cmd_b, cmd_cin));
      end
    end
  end

  // Cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("busy", busy, (mq.size() != 0));
        chk("rsp_count", rsp_count, mcnt);
        if (mq.size() == 0) begin
          chk("idle_alu_opcode", alu_opcode, 0);
          chk("idle_alu_a", alu_a, 0);
          chk("idle_alu_b", alu_b, 0);
          chk("idle_alu_cin", alu_cin, 0);
          chk("idle_rsp_valid", rsp_valid, 0);
        end else if (rsp_valid) begin
          chk("rsp_data", rsp_data, mq[0].data);
          chk("rsp_opcode", rsp_opcode, mq[0].op);
          chk("rsp_zero", rsp_zero, mq[0].zero);
          chk("rsp_err", rsp_err, mq[0].err);
          chk("held_alu_opcode", alu_opcode, mq[0].op);
          chk("held_alu_a", alu_a, mq[0].a);
          chk("held_alu_b", alu_b, mq[0].b);
          chk("held_alu_cin", alu_cin, mq[0].cin);
        end
        if (mq.size() < DEPTH)     chk("cmd_ready_room", cmd_ready, 1);
        if (mq.size() > DEPTH)     chk("cmd_ready_full", cmd_ready, 0);
      end
    end
  end

  task automatic push_cmd(input logic [3:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic cin);
    logic acc = 1'b0;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_cin    = cin;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
    end
    if (!acc) chk("push_timeout", 0, 1);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk);
      #2;
      done = !busy && !rsp_valid;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_log(input string name, input int idx, input logic [7:0] data,
                         input logic zero, input logic err);
    if (rlog.size() <= idx) begin
      chk({name, "_missing"}, rlog.size(), idx + 1);
    end else begin
      chk({name, "_data"}, rlog[idx].data, data);
      chk({name, "_zero"}, rlog[idx].zero, zero);
      chk({name, "_err"}, rlog[idx].err, err);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_alu"}, {alu_opcode, alu_a, alu_b, alu_cin}, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_fields"}, {rsp_data, rsp_opcode, rsp_zero, rsp_err}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_count"}, rsp_count, 0);
  endtask

  initial begin
    int base;
    logic [7:0] iv;

    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_reset_values("reset");

    // Single add with latency checks
    push_cmd(4'h3, 4'h9, 4'h8, 1'b1);
    @(posedge clk); #2;
    chk("add_n1_rsp_valid", rsp_valid, 0);
    chk("add_n1_alu", {alu_opcode, alu_a, alu_b, alu_cin}, {4'h3, 4'h9, 4'h8, 1'b1});
    @(posedge clk); #2;
    chk("add_n2_rsp_valid", rsp_valid, 1);
    chk("add_n2_rsp_data", rsp_data, 8'h12);
    chk("add_n2_flags", {rsp_zero, rsp_err}, 0);
    chk("add_n2_opcode", rsp_opcode, 4'h3);
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    chk("add_rsp_count", rsp_count, 1);
    chk("add_done_valid", rsp_valid, 0);
    chk("add_done_busy", busy, 0);

    // Divide by zero, then a legal divide
    base = rlog.size();
    rsp_ready = 1'b1;
    push_cmd(4'h6, 4'h7, 4'h0, 1'b0);
    push_cmd(4'h6, 4'h7, 4'h2, 1'b0);
    wait_idle();
    chk_log("div0", base, 8'hFF, 1'b0, 1'b1);
    chk_log("div72", base + 1, 8'h03, 1'b0, 1'b0);

    // Zero flag and other opcodes
    base = rlog.size();
    push_cmd(4'hD, 4'h5, 4'h5, 1'b0);
    push_cmd(4'h5, 4'hF, 4'hF, 1'b0);
    push_cmd(4'hE, 4'h3, 4'h3, 1'b0);
    wait_idle();
    chk_log("xor55", base, 8'h00, 1'b1, 1'b0);
    chk_log("mulff", base + 1, 8'hE1, 1'b0, 1'b0);
    chk_log("eq33", base + 2, 8'h01, 1'b0, 1'b0);
    rsp_ready = 1'b0;

    // Backpressure: fill the FIFO behind one held response
    base = rlog.size();
    fork
      begin
        for (int k = 1; k <= 6; k++) push_cmd(4'h3, 4'(k), 4'h2, 1'b0);
      end
      begin
        repeat (9) @(posedge clk);
        #2;
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_rsp_data", rsp_data, 8'h03);
        chk("bp_alu_a", alu_a, 4'h1);
        chk("bp_busy", busy, 1);
        rsp_ready = 1'b1;
      end
    join
    wait_idle();
    for (int k = 1; k <= 6; k++) chk_log("bp_order", base + k - 1, 8'(k + 2), 1'b0, 1'b0);
    rsp_ready = 1'b0;

    // Reset while one response is held and three are queued
    push_cmd(4'h9, 4'h1, 4'h2, 1'b0);
    push_cmd(4'h8, 4'hF, 4'h3, 1'b0);
    push_cmd(4'h1, 4'h4, 4'h0, 1'b0);
    push_cmd(4'h2, 4'h0, 4'h6, 1'b0);
    @(posedge clk); #2;
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    chk("pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    #1 chk_reset_values("midrst");
    #2 rst = 1'b0;
    @(posedge clk); #2;
    base = rlog.size();
    rsp_ready = 1'b1;
    push_cmd(4'h3, 4'h2, 4'h2, 1'b0);
    wait_idle();
    chk("post_rst_count", rsp_count, 1);
    chk("post_rst_nrsp", rlog.size() - base, 1);
    chk_log("post_rst", base, 8'h04, 1'b0, 1'b0);

    // Counter wrap: 255 more responses bring the count from 1 back to 0
    base = rlog.size();
    for (int i = 0; i < 255; i++) begin
      iv = 8'(i);
      push_cmd(iv[3:0], iv[7:4], iv[7:4] ^ iv[2:0], iv[0]);
    end
    wait_idle();
    chk("wrap_count", rsp_count, 8'h00);
    chk("wrap_nrsp", rlog.size() - base, 255);
    rsp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side initiator for the 4-bit combinational ALU: accepts operation commands (opcode, A, B, carry-in) over a valid/ready handshake, buffers them in a small FIFO and drives them onto the ALU operand/opcode inputs one at a time. It registers each 8-bit ALU result with status flags and returns it over a second valid/ready handshake. Sits between the top-level pin/command logic and the `alu` instance, so operands no longer need to be held static on the pins.

## Interface
- `DEPTH`, 4, command FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals !full.
- `cmd_opcode`  in  4  ALU opcode 0x0–0xF.
- `cmd_a`, `cmd_b`  in  4 each  operands.
- `cmd_cin`  in  1  carry/borrow in.
- `alu_opcode`, `alu_a`, `alu_b`  out  4 each  to ALU.
- `alu_cin`  out  1  to ALU.
- `alu_result`  in  8  combinational ALU output.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_data`  out  8  captured result.
- `rsp_opcode`  out  4  opcode that produced it.
- `rsp_zero`  out  1  rsp_data == 0.
- `rsp_err`  out  1  divide by zero (opcode 0x6, B == 0).
- `busy`  out  1  state != IDLE or FIFO non-empty.
- `rsp_count`  out  8  delivered responses, wraps 0xFF→0x00.

## Operation
- Push: `cmd_valid && cmd_ready` at an edge writes {opcode,a,b,cin} at the FIFO tail.
- FSM states IDLE, DRIVE, RESP.
- IDLE: all `alu_*` outputs 0 (opcode 0x0 = zero). If FIFO non-empty, pop head into issue register → DRIVE.
- DRIVE: `alu_*` driven from issue register (registered outputs, glitch-free). At the end of this cycle capture into response register: `rsp_data` = `alu_result`, except forced to 0xFF when err; `rsp_opcode`; `rsp_zero`; `rsp_err`; set `rsp_valid` → RESP.
- RESP: `alu_*` keep issue-register values; response held stable while `rsp_valid && !rsp_ready`. On `rsp_ready`: clear `rsp_valid`, increment `rsp_count`; if FIFO non-empty pop next → DRIVE, else → IDLE (issue register cleared).
- Push and pop in the same cycle: both happen; occupancy unchanged. Push is rejected while full, even if a pop occurs that cycle (no pass-through).
- FIFO pointers are log2(DEPTH)+1 bits wide. Full = MSBs differ and low bits are equal. Pointers wrap naturally.

## Timing
- Reset values: `cmd_ready`=1, all `alu_*`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_opcode`=0, `rsp_zero`=0, `rsp_err`=0, `busy`=0, `rsp_count`=0. FSM=IDLE, FIFO empty.
- Latency: command pushed at edge N into an idle, empty block:
  - popped at N+1 (`alu_*` valid after N+1);
  - `rsp_valid`=1 after N+2.
- Throughput: one response per 2 cycles when `rsp_ready` is held high.
- The ALU is a single-cycle combinational path: `alu_*` register → ALU → response register.
- Reset asserted mid-operation: FIFO contents, the in-flight command and any pending response are discarded immediately (async). No response is emitted for them.
- `rsp_count` increments only on a `rsp_valid && rsp_ready` edge.

## Structure
- Shared package `alu_pkg`:
  - opcode constants OP_ZERO(0x0) … OP_GT(0xF), including OP_DIV=0x6;
  - width constants (OPW=4, DW=4, RW=8);
  - FSM state encoding.
- Sub-module `alu_cmd_fifo`: parameterised synchronous FIFO (width 13, depth DEPTH) with push/pop/full/empty. The issuer holds the FSM, issue register and response register.

## Test plan
- Single add: push {0x3, A=0x9, B=0x8, cin=1}, `rsp_ready`=1 → `rsp_valid` 2 cycles later:
  - `rsp_data`=0x12, `rsp_zero`=0, `rsp_err`=0, `rsp_count`=1.
- Divide by zero: push {0x6, A=0x7, B=0x0} → `rsp_data`=0xFF, `rsp_err`=1. Then {0x6, 7, 2} → 0x03, `rsp_err`=0.
- Backpressure / full: `rsp_ready`=0, push 6 commands (DEPTH=4):
  - one is issued and held, 4 are queued, `cmd_ready`=0;
  - the 6th is stalled until the first `rsp_ready`;
  - responses then arrive in order with data stable while stalled.
- Zero flag and opcodes: push {0xD, 0x5, 0x5} → `rsp_data`=0x00, `rsp_zero`=1. {0x5, 0xF, 0xF} → 0xE1. {0xE, 3, 3} → 0x01.
- Reset mid-operation: with 3 queued and one in RESP, pulse `rst` between edges →
  - all outputs at reset values immediately;
  - a subsequent single push yields exactly one response, `rsp_count`=1.
- Counter wrap: 256 back-to-back responses → `rsp_count` returns to 0x00, with no lost or duplicated responses.
